gps_nmea_rx: RTL and testbench

GPS_NMEA_RX -- requirements
Module: gps_nmea_rx

---
 rtl/gps_nmea_rx.sv | 219 +++++++++++++++++++++
 tb/tb_gps_nmea_rx.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gps_nmea_rx.sv
// NMEA-0183 sentence receiver: UART byte decoder feeding a '$'..'*hh' framer
// that checks the XOR checksum and replays accepted sentence bodies on a ready/valid stream.
//   state | meaning
//   HUNT  | waiting for '$'
//   BODY  | buffering body bytes, accumulating XOR
//   CK_HI | expecting high checksum digit
//   CK_LO | expecting low checksum digit, then verdict
//   DRAIN | replaying buffered body downstream
module gps_nmea_rx #(
  parameter int SYSCLK_FREQ = 100_000_000,
  parameter int BAUD        = 9600,
  parameter int MAX_LEN     = 80,
  parameter int CNT_W       = 16
) (
  input  logic             sclk,
  input  logic             rst,
  input  logic             rxd,
  output logic [7:0]       m_data,
  output logic             m_valid,
  output logic             m_last,
  input  logic             m_ready,
  output logic             sentence_ok,
  output logic             cksum_err,
  output logic             frame_err,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             busy
);

  localparam int CLKS_PER_BIT = SYSCLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int TW           = $clog2(CLKS_PER_BIT + 1);
  localparam int PW           = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} ustate_t;
  typedef enum logic [2:0] {HUNT, BODY, CK_HI, CK_LO, DRAIN} fstate_t;

  ustate_t ust, ust_nxt;
  logic rxd_s1, rxd_s2, rxd_d;
  logic [TW-1:0] tmr;
  logic tmr_tc;
  logic [2:0] bit_idx;
  logic [7:0] shreg;
  logic byte_stb;

  assign tmr_tc = (tmr == '0);

  always_ff @(posedge sclk) begin
    if (rst) ust <= U_IDLE;
    else     ust <= ust_nxt;
  end

  always_comb begin
    ust_nxt = ust;
    case (ust)
      U_IDLE:  if (rxd_d && !rxd_s2) ust_nxt = U_START;
      U_START: if (tmr_tc) ust_nxt = rxd_s2 ? U_IDLE : U_DATA;
      U_DATA:  if (tmr_tc && bit_idx == 3'd7) ust_nxt = U_STOP;
      U_STOP:  if (tmr_tc) ust_nxt = U_IDLE;
      default: ust_nxt = U_IDLE;
    endcase
  end

  // Timer is preloaded with the half-bit count while idle so the start bit is checked mid-bit.
  always_ff @(posedge sclk) begin
    if (rst) begin
      rxd_s1    <= 1'b1;
      rxd_s2    <= 1'b1;
      rxd_d     <= 1'b1;
      tmr       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      byte_stb  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rxd_s1    <= rxd;
      rxd_s2    <= rxd_s1;
      rxd_d     <= rxd_s2;
      byte_stb  <= 1'b0;
      frame_err <= 1'b0;
      if (ust == U_IDLE) begin
        tmr     <= TW'(HALF_BIT - 1);
        bit_idx <= '0;
      end else if (tmr_tc) begin
        tmr <= TW'(CLKS_PER_BIT - 1);
        if (ust == U_DATA) begin
          shreg   <= {rxd_s2, shreg[7:1]};
          bit_idx <= bit_idx + 3'd1;
        end
        if (ust == U_STOP) begin
          byte_stb  <= rxd_s2;
          frame_err <= !rxd_s2;
        end
      end else begin
        tmr <= tmr - TW'(1);
      end
    end
  end

  function automatic logic [4:0] hex_val(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39)      return {1'b0, 4'(c - 8'h30)};
    else if (c >= 8'h41 && c <= 8'h46) return {1'b0, 4'(c - 8'h37)};
    else if (c >= 8'h61 && c <= 8'h66) return {1'b0, 4'(c - 8'h57)};
    else                               return 5'h10;
  endfunction

  fstate_t fst, fst_nxt;
  logic [7:0] mem [2**PW];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [7:0] acc;
  logic [3:0] ck_hi_nib;
  logic ck_bad;
  logic [4:0] hex_cur;
  logic do_clr, do_store, do_drop, do_ok, do_err, do_hi, do_adv;

  assign hex_cur = hex_val(shreg);
  assign busy    = (fst != HUNT);
  assign m_valid = (fst == DRAIN);
  assign m_last  = m_valid && (rd_ptr == wr_ptr - PW'(1));
  assign m_data  = m_valid ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge sclk) begin
    if (rst) fst <= HUNT;
    else     fst <= fst_nxt;
  end

  always_comb begin
    fst_nxt  = fst;
    do_clr   = 1'b0;
    do_store = 1'b0;
    do_drop  = 1'b0;
    do_ok    = 1'b0;
    do_err   = 1'b0;
    do_hi    = 1'b0;
    do_adv   = 1'b0;
    case (fst)
      HUNT: if (byte_stb && shreg == 8'h24) begin
        fst_nxt = BODY;
        do_clr  = 1'b1;
      end
      BODY: if (frame_err) begin
        fst_nxt = HUNT;
        do_drop = 1'b1;
      end else if (byte_stb) begin
        if (shreg == 8'h2A) fst_nxt = CK_HI;
        else if (shreg == 8'h24) begin
          do_clr  = 1'b1;
          do_drop = 1'b1;
        end else if (wr_ptr == PW'(MAX_LEN)) begin
          fst_nxt = HUNT;
          do_drop = 1'b1;
        end else do_store = 1'b1;
      end
      CK_HI: if (frame_err) begin
        fst_nxt = HUNT;
        do_drop = 1'b1;
      end else if (byte_stb) begin
        do_hi   = 1'b1;
        fst_nxt = CK_LO;
      end
      CK_LO: if (frame_err) begin
        fst_nxt = HUNT;
        do_drop = 1'b1;
      end else if (byte_stb) begin
        if (ck_bad || hex_cur[4] || {ck_hi_nib, hex_cur[3:0]} != acc || wr_ptr == '0) begin
          do_err  = 1'b1;
          do_drop = 1'b1;
          fst_nxt = HUNT;
        end else begin
          do_ok   = 1'b1;
          fst_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (byte_stb && shreg == 8'h24) do_drop = 1'b1;
        if (m_ready) begin
          if (m_last) fst_nxt = HUNT;
          else        do_adv  = 1'b1;
        end
      end
      default: fst_nxt = HUNT;
    endcase
  end

  always_ff @(posedge sclk) begin
    if (do_store) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      acc         <= '0;
      ck_hi_nib   <= '0;
      ck_bad      <= 1'b0;
      drop_cnt    <= '0;
      sentence_ok <= 1'b0;
      cksum_err   <= 1'b0;
    end else begin
      sentence_ok <= do_ok;
      cksum_err   <= do_err;
      if (do_clr) begin
        wr_ptr <= '0;
        acc    <= '0;
      end
      if (do_store) begin
        wr_ptr <= wr_ptr + PW'(1);
        acc    <= acc ^ shreg;
      end
      if (do_hi) begin
        ck_hi_nib <= hex_cur[3:0];
        ck_bad    <= hex_cur[4];
      end
      if (do_ok)       rd_ptr <= '0;
      else if (do_adv) rd_ptr <= rd_ptr + PW'(1);
      if (do_drop && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_gps_nmea_rx.sv
// Directed bench for gps_nmea_rx: two instances at 8 clocks/bit, one with a
// full-size buffer and one with MAX_LEN=4 and a 2-bit drop counter.
module tb_gps_nmea_rx;

  logic sclk = 1'b0;
  always #5 sclk = ~sclk;

  logic rst;
  logic rxd_a, rxd_b, m_ready_a, m_ready_b;
  logic [7:0] m_data_a, m_data_b;
  logic m_valid_a, m_valid_b, m_last_a, m_last_b;
  logic sentence_ok_a, sentence_ok_b, cksum_err_a, cksum_err_b;
  logic frame_err_a, frame_err_b, busy_a, busy_b;
  logic [15:0] drop_a;
  logic [1:0]  drop_b;

  gps_nmea_rx #(.SYSCLK_FREQ(1_000_000), .BAUD(115200), .MAX_LEN(80), .CNT_W(16)) dut_a (
    .sclk(sclk), .rst(rst), .rxd(rxd_a), .m_data(m_data_a), .m_valid(m_valid_a),
    .m_last(m_last_a), .m_ready(m_ready_a), .sentence_ok(sentence_ok_a),
    .cksum_err(cksum_err_a), .frame_err(frame_err_a), .drop_cnt(drop_a), .busy(busy_a));

  gps_nmea_rx #(.SYSCLK_FREQ(1_000_000), .BAUD(115200), .MAX_LEN(4), .CNT_W(2)) dut_b (
    .sclk(sclk), .rst(rst), .rxd(rxd_b), .m_data(m_data_b), .m_valid(m_valid_b),
    .m_last(m_last_b), .m_ready(m_ready_b), .sentence_ok(sentence_ok_b),
    .cksum_err(cksum_err_b), .frame_err(frame_err_b), .drop_cnt(drop_b), .busy(busy_b));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int ok_a = 0, err_a = 0, fe_a = 0, vld_a = 0;
  int ok_b = 0, err_b = 0, fe_b = 0, vld_b = 0;
  logic [8:0] q_a[$];
  logic [8:0] q_b[$];

  always @(negedge sclk) begin
    if (sentence_ok_a) ok_a++;
    if (cksum_err_a)   err_a++;
    if (frame_err_a)   fe_a++;
    if (m_valid_a)     vld_a++;
    if (m_valid_a && m_ready_a) q_a.push_back({m_last_a, m_data_a});
  end

  always @(negedge sclk) begin
    if (sentence_ok_b) ok_b++;
    if (cksum_err_b)   err_b++;
    if (frame_err_b)   fe_b++;
    if (m_valid_b)     vld_b++;
    if (m_valid_b && m_ready_b) q_b.push_back({m_last_b, m_data_b});
  end

  task automatic set_line(input bit sel, input logic v);
    if (sel) rxd_b = v;
    else     rxd_a = v;
  endtask

  task automatic send_byte(input bit sel, input logic [7:0] b, input bit stop);
    set_line(sel, 1'b0);
    repeat (8) @(posedge sclk);
    #1;
    for (int i = 0; i < 8; i++) begin
      set_line(sel, b[i]);
      repeat (8) @(posedge sclk);
      #1;
    end
    set_line(sel, stop);
    repeat (8) @(posedge sclk);
    #1;
    set_line(sel, 1'b1);
    repeat (4) @(posedge sclk);
    #1;
  endtask

  task automatic send_str(input bit sel, input string s);
    for (int i = 0; i < s.len(); i++) send_byte(sel, s[i], 1'b1);
  endtask

  task automatic wait_valid(input bit sel, input string tag);
    int n = 0;
    while (!(sel ? m_valid_b : m_valid_a) && n < 300) begin
      @(negedge sclk);
      n++;
    end
    check(tag, sel ? m_valid_b : m_valid_a, 1);
  endtask

  task automatic check_bytes(input bit sel, input string tag, input string exp);
    logic [8:0] q[$];
    logic [8:0] got;
    if (sel) q = q_b;
    else     q = q_a;
    check({tag, "_len"}, q.size(), exp.len());
    for (int i = 0; i < exp.len(); i++) begin
      got = (i < q.size()) ? q[i] : 9'h1FF;
      check(tag, got, {(i == exp.len() - 1), exp[i]});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  int b_ok, b_err, b_fe, b_vld;
  logic [15:0] d0;

  initial begin
    rst = 1'b1;
    rxd_a = 1'b1;
    rxd_b = 1'b1;
    m_ready_a = 1'b1;
    m_ready_b = 1'b1;
    repeat (5) @(posedge sclk);
    @(negedge sclk);
    check("rst_outs_a", {m_valid_a, m_last_a, sentence_ok_a, cksum_err_a, frame_err_a, busy_a}, 0);
    check("rst_data_a", m_data_a, 8'h00);
    check("rst_drop_a", drop_a, 0);
    check("rst_outs_b", {m_valid_b, m_last_b, sentence_ok_b, cksum_err_b, frame_err_b, busy_b}, 0);
    check("rst_drop_b", drop_b, 0);
    @(posedge sclk);
    #1 rst = 1'b0;
    repeat (3) @(posedge sclk);
    #1;

    // XOR of "GPGLL,4916.45,N" = 0x3B
    b_ok = ok_a; b_err = err_a;
    q_a.delete();
    send_str(0, "$GPGLL,4916.45,N*3B\r\n");
    repeat (5) @(negedge sclk);
    check("good_ok", ok_a - b_ok, 1);
    check("good_err", err_a - b_err, 0);
    check_bytes(0, "good_data", "GPGLL,4916.45,N");
    check("good_busy", busy_a, 0);

    b_err = err_a; b_vld = vld_a; b_ok = ok_a;
    send_str(0, "$AB*00");
    repeat (5) @(negedge sclk);
    check("bad_err", err_a - b_err, 1);
    check("bad_drop", drop_a, 1);
    check("bad_valid", vld_a - b_vld, 0);
    check("bad_ok", ok_a - b_ok, 0);

    m_ready_a = 1'b0;
    q_a.delete();
    send_str(0, "$A*41");
    wait_valid(0, "bp_valid");
    for (int i = 0; i < 10; i++) begin
      @(negedge sclk);
      check("bp_hold", {m_valid_a, m_last_a, m_data_a}, {1'b1, 1'b1, 8'h41});
    end
    @(posedge sclk);
    #1 m_ready_a = 1'b1;
    @(posedge sclk);
    @(negedge sclk);
    check("bp_busy", busy_a, 0);
    check("bp_valid_low", m_valid_a, 0);
    check_bytes(0, "bp_xfer", "A");

    b_ok = ok_a;
    q_a.delete();
    send_str(0, "$Z*5a");
    repeat (5) @(negedge sclk);
    check("lower_ok", ok_a - b_ok, 1);
    check_bytes(0, "lower_data", "Z");

    b_err = err_a;
    send_str(0, "$A*4G");
    repeat (5) @(negedge sclk);
    check("nonhex_err", err_a - b_err, 1);
    check("nonhex_drop", drop_a, 2);

    b_err = err_a; b_vld = vld_a;
    send_str(0, "$*00");
    repeat (5) @(negedge sclk);
    check("empty_err", err_a - b_err, 1);
    check("empty_drop", drop_a, 3);
    check("empty_valid", vld_a - b_vld, 0);

    b_ok = ok_a;
    q_a.delete();
    send_str(0, "$XY$A*41");
    repeat (5) @(negedge sclk);
    check("restart_drop", drop_a, 4);
    check("restart_ok", ok_a - b_ok, 1);
    check_bytes(0, "restart_data", "A");

    b_fe = fe_a; b_vld = vld_a; b_ok = ok_a;
    send_str(0, "$AB");
    send_byte(0, 8'h43, 1'b0);
    send_str(0, "*03");
    repeat (5) @(negedge sclk);
    check("fe_pulse", fe_a - b_fe, 1);
    check("fe_valid", vld_a - b_vld, 0);
    check("fe_ok", ok_a - b_ok, 0);
    check("fe_busy", busy_a, 0);

    m_ready_a = 1'b0;
    send_str(0, "$A*41");
    wait_valid(0, "rd_valid");
    d0 = drop_a;
    send_byte(0, 8'h24, 1'b1);
    @(negedge sclk);
    check("drain_dollar_drop", drop_a, d0 + 16'd1);
    check("drain_hold", {m_valid_a, m_last_a, m_data_a}, {1'b1, 1'b1, 8'h41});
    @(posedge sclk);
    #1 rst = 1'b1;
    @(posedge sclk);
    @(negedge sclk);
    check("rst_drain_valid", m_valid_a, 0);
    check("rst_drain_drop", drop_a, 0);
    check("rst_drain_busy", busy_a, 0);
    @(posedge sclk);
    #1 rst = 1'b0;
    m_ready_a = 1'b1;
    repeat (3) @(posedge sclk);
    #1;

    b_ok = ok_b; b_vld = vld_b;
    send_str(1, "$ABCDE*..");
    repeat (5) @(negedge sclk);
    check("ovf_drop", drop_b, 1);
    check("ovf_ok", ok_b - b_ok, 0);
    check("ovf_valid", vld_b - b_vld, 0);
    check("ovf_busy", busy_b, 0);

    b_ok = ok_b;
    q_b.delete();
    send_str(1, "$AB*03");
    repeat (5) @(negedge sclk);
    check("after_ovf_ok", ok_b - b_ok, 1);
    check_bytes(1, "after_ovf_data", "AB");

    b_ok = ok_b;
    q_b.delete();
    send_str(1, "$ABCD*04");
    repeat (5) @(negedge sclk);
    check("full_ok", ok_b - b_ok, 1);
    check_bytes(1, "full_data", "ABCD");

    send_str(1, "$A*00");
    repeat (5) @(negedge sclk);
    check("sat_drop_2", drop_b, 2);
    send_str(1, "$A*00");
    repeat (5) @(negedge sclk);
    check("sat_drop_3", drop_b, 3);
    b_err = err_b;
    send_str(1, "$A*00");
    repeat (5) @(negedge sclk);
    check("sat_hold", drop_b, 3);
    check("sat_err", err_b - b_err, 1);
    check("end_busy_b", busy_b, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
